// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a START/DONE handshake.
// Single-cycle ops: FWD, ADD, AND, OR, SUB. The SLL/SRL/SRA/ROR shifts move
// one bit per cycle. The shift-add multiplier is built only when
// ALU_SEQ_MULT_EN is defined. Without it, opcode 0101 completes as illegal.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             ILLEGAL
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so the counter can hold WIDTH as the multiplier step count.
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_FWD  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
`ifdef ALU_SEQ_MULT_EN
  localparam logic [3:0] OP_MULT = 4'b0101;
`endif
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_ROR  = 4'b1001;

`ifdef ALU_SEQ_MULT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             illegal_q;
  logic             done_q;
`ifdef ALU_SEQ_MULT_EN
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_step;
  logic             is_mult;
`endif

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [SHW-1:0]   shift_amt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cry;
  logic             alu_ill;
  logic             is_shift;
  logic [WIDTH-1:0] shift_step;
  logic             last_step;

  assign shift_amt = DATA2[SHW-1:0];
  assign last_step = (cnt_q == CW'(1));

  // Decode the incoming opcode and compute every single-cycle result
  always_comb begin
    sum_add  = {1'b0, DATA1} + {1'b0, DATA2};
    sum_sub  = {1'b0, DATA1} + {1'b0, ~DATA2} + (WIDTH+1)'(1);
    alu_res  = '0;
    alu_cry  = 1'b0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
`ifdef ALU_SEQ_MULT_EN
    is_mult  = 1'b0;
`endif
    case (SELECT)
      OP_FWD:  alu_res = DATA2;
      OP_ADD:  begin alu_res = sum_add[WIDTH-1:0]; alu_cry = sum_add[WIDTH]; end
      OP_AND:  alu_res = DATA1 & DATA2;
      OP_OR:   alu_res = DATA1 | DATA2;
      OP_SUB:  begin alu_res = sum_sub[WIDTH-1:0]; alu_cry = sum_sub[WIDTH]; end
`ifdef ALU_SEQ_MULT_EN
      OP_MULT: is_mult = 1'b1;
`endif
      // A zero shift amount finishes immediately with A unchanged.
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
        is_shift = 1'b1;
        alu_res  = DATA1;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // One-bit step of the latched shift/rotate op
  always_comb begin
    shift_step = work_q;
    case (op_q)
      OP_SLL:  shift_step = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  shift_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_ROR:  shift_step = {work_q[0], work_q[WIDTH-1:1]};
      default: shift_step = work_q;
    endcase
  end

`ifdef ALU_SEQ_MULT_EN
  // Shift-add step: add the shifted multiplicand when the multiplier LSB is set
  always_comb begin
    acc_step = mplier_q[0] ? (acc_q + work_q) : acc_q;
  end
`endif

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
`ifdef ALU_SEQ_MULT_EN
          if (is_mult) state_d = S_MULT;
          else
`endif
          if (is_shift && (shift_amt != '0)) state_d = S_SHIFT;
        end
      end
      S_SHIFT: if (last_step) state_d = S_IDLE;
`ifdef ALU_SEQ_MULT_EN
      S_MULT:  if (last_step) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: BUSY follows the state, the rest come from the result registers
  always_comb begin
    BUSY    = (state_q != S_IDLE);
    DONE    = done_q;
    RESULT  = result_q;
    ZERO    = (result_q == '0);
    CARRY   = carry_q;
    ILLEGAL = illegal_q;
  end

  // Datapath: operand latch, iteration registers and result registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      op_q      <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_SEQ_MULT_EN
      mplier_q  <= '0;
      acc_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            op_q   <= SELECT;
            work_q <= DATA1;
`ifdef ALU_SEQ_MULT_EN
            if (is_mult) begin
              mplier_q <= DATA2;
              acc_q    <= '0;
              cnt_q    <= CW'(WIDTH);
            end else
`endif
            if (is_shift && (shift_amt != '0)) begin
              cnt_q <= {1'b0, shift_amt};
            end else begin
              result_q  <= alu_res;
              carry_q   <= alu_cry;
              illegal_q <= alu_ill;
              done_q    <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          work_q <= shift_step;
          cnt_q  <= cnt_q - CW'(1);
          if (last_step) begin
            result_q  <= shift_step;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
`ifdef ALU_SEQ_MULT_EN
        S_MULT: begin
          acc_q    <= acc_step;
          work_q   <= work_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (last_step) begin
            result_q  <= acc_step;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8). Expected results go into a scoreboard
// queue when an op is issued and are compared when DONE is seen.
module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic [3:0] SELECT = 4'd0;
  logic [7:0] DATA1 = 8'd0;
  logic [7:0] DATA2 = 8'd0;
  logic       BUSY, DONE, ZERO, CARRY, ILLEGAL;
  logic [7:0] RESULT;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY), .DONE(DONE),
    .RESULT(RESULT), .ZERO(ZERO), .CARRY(CARRY), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic       cry;
    logic       ill;
    int         lat;
    int         start;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every completion against the oldest outstanding expectation
  always @(negedge CLK) begin
    if (RESET && DONE) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %s: result=%02h carry=%0b illegal=%0b zero=%0b latency=%0d",
                 e.tag, RESULT, CARRY, ILLEGAL, ZERO, cyc - e.start);
        check({e.tag, "_result"},  RESULT, e.res);
        check({e.tag, "_carry"},   CARRY, e.cry);
        check({e.tag, "_illegal"}, ILLEGAL, e.ill);
        check({e.tag, "_zero"},    ZERO, (e.res == 8'h00));
        check({e.tag, "_latency"}, cyc - e.start, e.lat);
      end
    end
  end

  // Drive START in the current (low) half-cycle and record the expectation
  task automatic drive_now(input string tag, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] res, input logic cry,
                           input logic ill, input int lat);
    exp_t e;
    SELECT = op; DATA1 = a; DATA2 = b; START = 1'b1;
    e.tag = tag; e.res = res; e.cry = cry; e.ill = ill; e.lat = lat; e.start = cyc;
    sb.push_back(e);
    @(negedge CLK);
    START  = 1'b0;
    SELECT = 4'($urandom);
    DATA1  = 8'($urandom);
    DATA2  = 8'($urandom);
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] res, input logic cry,
                       input logic ill, input int lat);
    int guard = 0;
    @(negedge CLK);
    while (BUSY && guard < 40) begin @(negedge CLK); guard++; end
    if (guard >= 40) check("busy_timeout", 32'd1, 32'd0);
    drive_now(tag, op, a, b, res, cry, ill, lat);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 60) begin @(negedge CLK); guard++; end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    int dones;
    int guard;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_result", RESULT, 8'h00);
    check("rst_zero", ZERO, 1);
    check("rst_carry", CARRY, 0);
    check("rst_illegal", ILLEGAL, 0);
    RESET = 1'b1;

    // Give RESULT a nonzero value so the mid-op reset visibly clears it
    issue("fwd_pre", 4'b0000, 8'h00, 8'h5A, 8'h5A, 0, 0, 1);
    drain();

    // Asynchronous reset in the 4th busy cycle of a long op
    @(negedge CLK);
`ifdef ALU_SEQ_MULT_EN
    SELECT = 4'b0101; DATA1 = 8'd13; DATA2 = 8'd11;
`else
    SELECT = 4'b1000; DATA1 = 8'h55; DATA2 = 8'h07;
`endif
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("midop_busy1", BUSY, 1);
    repeat (3) @(negedge CLK);
    check("midop_busy4", BUSY, 1);
    #2 RESET = 1'b0;
    #1;
    check("async_busy", BUSY, 0);
    check("async_done", DONE, 0);
    check("async_result", RESULT, 8'h00);
    check("async_zero", ZERO, 1);
    @(negedge CLK);
    RESET = 1'b1;
    dones = 0;
    repeat (12) begin @(negedge CLK); if (DONE) dones++; end
    check("post_reset_dones", dones, 0);

    // ADD / SUB
    issue("add_f0_20", 4'b0001, 8'hF0, 8'h20, 8'h10, 1, 0, 1);
    issue("sub_05_05", 4'b0100, 8'h05, 8'h05, 8'h00, 1, 0, 1);
    issue("sub_03_04", 4'b0100, 8'h03, 8'h04, 8'hFF, 0, 0, 1);
    issue("and_cc_aa", 4'b0010, 8'hCC, 8'hAA, 8'h88, 0, 0, 1);

    // Shifts and rotate
    issue("sra_90_3",  4'b1000, 8'h90, 8'h03, 8'hF2, 0, 0, 4);
    issue("ror_81_1",  4'b1001, 8'h81, 8'h01, 8'hC0, 0, 0, 2);
    issue("sll_01_0",  4'b0110, 8'h01, 8'h08, 8'h01, 0, 0, 1);
    issue("srl_f0_fc", 4'b0111, 8'hF0, 8'hFC, 8'h0F, 0, 0, 5);
    drain();

    // Multiplier
`ifdef ALU_SEQ_MULT_EN
    issue("mult_13_11", 4'b0101, 8'd13, 8'd11, 8'h8F, 0, 0, 9);
    issue("mult_20_20", 4'b0101, 8'd20, 8'd20, 8'h90, 0, 0, 9);
`else
    issue("mult_off_13_11", 4'b0101, 8'd13, 8'd11, 8'h00, 0, 1, 1);
    issue("mult_off_20_20", 4'b0101, 8'd20, 8'd20, 8'h00, 0, 1, 1);
`endif
    drain();

    // START while BUSY is ignored
    issue("sll_03_4", 4'b0110, 8'h03, 8'h04, 8'h30, 0, 0, 5);
    check("hs_busy", BUSY, 1);
    SELECT = 4'b0111; DATA1 = 8'h80; DATA2 = 8'h07; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    drain();

    // Back-to-back issue in the DONE cycle
    issue("ror_b2b", 4'b1001, 8'h81, 8'h01, 8'hC0, 0, 0, 2);
    guard = 0;
    while (!DONE && guard < 20) begin @(negedge CLK); guard++; end
    check("b2b_done_seen", DONE, 1);
    check("b2b_busy_in_done", BUSY, 0);
    drive_now("or_b2b", 4'b0011, 8'h0F, 8'hF0, 8'hFF, 0, 0, 1);
    drain();

    // Illegal opcode, then FWD clears ILLEGAL
    issue("illegal_f", 4'b1111, 8'h12, 8'h34, 8'h00, 0, 1, 1);
    issue("fwd_5a",    4'b0000, 8'h77, 8'h5A, 8'h5A, 0, 0, 1);
    drain();

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the CPU datapath ALU.
- Keeps the single-cycle ops FORWARD, ADD, AND and OR, and adds SUB, iterative shifts/rotate and an optional shift-add multiplier.
- Operands and opcode are latched on a START handshake; the result is registered and flagged by a one-cycle DONE pulse.
- Sits between the register file and the writeback mux. The control unit stalls on BUSY.

Parameters:
- WIDTH, 8: operand and result width in bits, >= 2.
- SHW, $clog2(WIDTH): localparam, shift-amount field width (not overridable).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only when BUSY=0.
- SELECT  input  4  opcode.
- DATA1  input  WIDTH  operand A.
- DATA2  input  WIDTH  operand B; also supplies the shift amount.
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  one-cycle pulse when RESULT updates.
- RESULT  output  WIDTH  registered result.
- ZERO  output  1  high when RESULT == 0.
- CARRY  output  1  ADD carry-out, or SUB no-borrow.
- ILLEGAL  output  1  last completed opcode was unsupported.

Behaviour:
- Reset (RESET=0, asynchronous, any state, including mid-operation):
  - state=IDLE.
  - BUSY=0, DONE=0, RESULT=0, CARRY=0, ILLEGAL=0.
  - ZERO=1.
  - The in-flight operation is discarded.
- Opcodes:
  - 0000 FWD (RESULT=B)
  - 0001 ADD
  - 0010 AND
  - 0011 OR
  - 0100 SUB (A-B)
  - 0101 MULT
  - 0110 SLL
  - 0111 SRL
  - 1000 SRA
  - 1001 ROR
  - 1010-1111 illegal.
- FSM states: IDLE, SHIFT, MULT.
- IDLE:
  - On START=1, latch A, B and SELECT.
  - Single-cycle or illegal opcode: RESULT/flags are written at that same edge and DONE=1 for the following cycle. Latency 1, state stays IDLE.
  - Shift opcode with amount N=B[SHW-1:0]:
    - N=0: complete like a single-cycle op.
    - N>0: go to SHIFT with counter=N and BUSY=1.
  - MULT: go to MULT with counter=WIDTH, accumulator=0, BUSY=1.
- SHIFT state:
  - Each cycle, shift the working register by one bit and decrement the counter.
  - When the counter reaches 0, write RESULT, clear BUSY, pulse DONE and return to IDLE.
  - Latency N+1 cycles from the START edge to the DONE cycle.
  - SRA replicates the MSB. ROR moves bit 0 into the MSB. SLL and SRL fill with 0.
  - Amount uses the low SHW bits of B only; upper bits are ignored.
- MULT state:
  - One shift-add step per cycle, WIDTH steps.
  - RESULT = low WIDTH bits of A*B (unsigned).
  - Latency WIDTH+1.
- Arithmetic rules:
  - ADD/SUB use WIDTH+1-bit internal arithmetic. RESULT is the low WIDTH bits and CARRY is bit WIDTH.
  - SUB is computed as A + ~B + 1, so CARRY=1 means A >= B unsigned.
  - All other ops write CARRY=0.
- ILLEGAL:
  - Updated on every completion: 1 for illegal opcodes, otherwise 0.
  - Illegal opcodes write RESULT=0.
- Handshake:
  - START while BUSY=1 is ignored; operands are not re-latched.
  - In the DONE cycle, state=IDLE and BUSY=0, so a START in that cycle is accepted (back-to-back issue).
  - DONE is never asserted two cycles in a row for a single op.
- Hold rules:
  - RESULT, CARRY and ILLEGAL hold their values between completions.
  - ZERO is combinational from the RESULT register.
- Input stability: operand or SELECT changes after the START edge have no effect on the in-flight op.

Optional Feature:
- Macro: ALU_SEQ_MULT_EN.
- Defined: the MULT state and the shift-add datapath are present, and opcode 0101 behaves as above.
- Undefined:
  - No multiplier logic and no MULT state.
  - Opcode 0101 is treated as illegal: latency 1, RESULT=0, ILLEGAL=1, CARRY=0.

Test Plan:
1. Reset: assert RESET=0 for 2 cycles, then issue MULT 13*11 and drive RESET=0 in the 4th busy cycle -> asynchronously BUSY=0, DONE=0, RESULT=8'h00, ZERO=1, and no DONE after release.
2. ADD and SUB:
   - ADD A=8'hF0, B=8'h20 -> DONE one cycle after START; RESULT=8'h10, CARRY=1, ZERO=0.
   - SUB A=8'h05, B=8'h05 -> RESULT=8'h00, ZERO=1, CARRY=1.
   - SUB 8'h03-8'h04 -> RESULT=8'hFF, CARRY=0.
3. Shifts and rotate:
   - SRA A=8'h90, B=8'h03 -> BUSY for 3 cycles, DONE at cycle 4, RESULT=8'hF2.
   - ROR A=8'h81, B=8'h01 -> RESULT=8'hC0, latency 2.
   - SLL A=8'h01, B=8'h08 (amount 0) -> RESULT=8'h01, latency 1.
4. MULT (macro on):
   - 13*11 -> RESULT=8'h8F, DONE at cycle 9.
   - 20*20 -> RESULT=8'h90.
   - Macro off: the same stimulus gives RESULT=8'h00, ILLEGAL=1, latency 1.
5. Handshake:
   - START with SRL A=8'h80, B=8'h07 while BUSY from a prior op -> ignored; the prior RESULT completes unchanged.
   - START of OR A=8'h0F, B=8'hF0 in the DONE cycle -> accepted; RESULT=8'hFF on the next DONE.
6. Illegal: SELECT=4'b1111 -> DONE after 1 cycle, RESULT=8'h00, ZERO=1, ILLEGAL=1; the following FWD B=8'h5A clears ILLEGAL and gives RESULT=8'h5A.
